// File: rtl/riscv_pkg.sv
// Shared register-file widths and the writeback entry carried through the load buffer.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    WB_SRC_NONE = 2'd0,
    WB_SRC_ALU  = 2'd1,
    WB_SRC_LOAD = 2'd2
  } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// In-order buffer of accepted load results waiting for a register-file write slot.
module wb_fifo
  import riscv_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  wb_entry_t     i_push_data,
  input  logic          i_pop,
  output wb_entry_t     o_head,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  wb_entry_t     r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Storage needs no reset: an entry is only read once the count says it was written.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Single-port register-file writeback shared by the ALU and buffered load results,
// with a starvation guard that periodically stalls the ALU and a pending-load scoreboard.
module writeback_arbiter
  import riscv_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  AluValid,
  input  logic [REG_ADDR_W-1:0] AluRd,
  input  logic [XLEN-1:0]       AluData,
  output logic                  AluStall,
  input  logic                  LdValid,
  output logic                  LdReady,
  input  logic [REG_ADDR_W-1:0] LdRd,
  input  logic [XLEN-1:0]       LdData,
  input  logic                  IssueLoad,
  input  logic [REG_ADDR_W-1:0] IssueRd,
  output logic [NUM_REGS-1:0]   Pending,
  output logic [REG_ADDR_W-1:0] A3,
  output logic [XLEN-1:0]       WD3,
  output logic                  RegWrite
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic                  r_regwrite;
  logic [REG_ADDR_W-1:0] r_a3;
  logic [XLEN-1:0]       r_wd3;
  logic                  r_alu_stall;
  logic [SW-1:0]         r_starve;
  logic [NUM_REGS-1:0]   r_pending;

  logic                  w_push;
  wb_entry_t             w_push_data;
  logic                  w_pop;
  wb_entry_t             w_head;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [CW-1:0]         w_fifo_count;
  wb_src_e               w_src;
  wb_entry_t             w_sel;
  logic [SW-1:0]         w_starve_nxt;
  logic [NUM_REGS-1:0]   w_pend_nxt;

  // Ready comes from the registered count only, so a pop never frees a slot in the same cycle.
  assign LdReady     = RESET_N & ~w_fifo_full & (w_fifo_count < CW'(FIFO_DEPTH));
  assign w_push      = LdValid & LdReady;
  assign w_push_data = '{rd: LdRd, data: LdData};

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (CLK),
    .i_rst_n     (RESET_N),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_count     (w_fifo_count)
  );

  always_comb begin
    w_src = WB_SRC_NONE;
    w_sel = '0;
    w_pop = 1'b0;
    if (AluValid && !r_alu_stall) begin
      w_src = WB_SRC_ALU;
      w_sel = '{rd: AluRd, data: AluData};
    end else if (!w_fifo_empty) begin
      w_src = WB_SRC_LOAD;
      w_sel = w_head;
      w_pop = 1'b1;
    end
  end

  always_comb begin
    w_starve_nxt = r_starve;
    if (w_fifo_empty || w_pop) begin
      w_starve_nxt = '0;
    end else if (w_src == WB_SRC_ALU && r_starve != SW'(STARVE_LIMIT)) begin
      w_starve_nxt = r_starve + SW'(1);
    end
  end

  // A new issue to the same rd outranks the retiring load's clear.
  always_comb begin
    w_pend_nxt = r_pending;
    if (w_src == WB_SRC_LOAD) begin
      w_pend_nxt[w_sel.rd] = 1'b0;
    end
    if (IssueLoad && IssueRd != '0) begin
      w_pend_nxt[IssueRd] = 1'b1;
    end
    w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_regwrite  <= 1'b0;
      r_a3        <= '0;
      r_wd3       <= '0;
      r_alu_stall <= 1'b0;
      r_starve    <= '0;
      r_pending   <= '0;
    end else begin
      r_regwrite  <= (w_src != WB_SRC_NONE) && (w_sel.rd != '0);
      r_a3        <= w_sel.rd;
      r_wd3       <= w_sel.data;
      r_alu_stall <= (w_starve_nxt == SW'(STARVE_LIMIT));
      r_starve    <= w_starve_nxt;
      r_pending   <= w_pend_nxt;
    end
  end

  assign RegWrite = r_regwrite;
  assign A3       = r_a3;
  assign WD3      = r_wd3;
  assign AluStall = r_alu_stall;
  assign Pending  = r_pending;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: expected writes are queued as stimulus is driven
// and matched against every RegWrite the DUT produces.
module tb_writeback_arbiter;
  import riscv_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        AluValid;
  logic [4:0]  AluRd;
  logic [31:0] AluData;
  logic        AluStall;
  logic        LdValid;
  logic        LdReady;
  logic [4:0]  LdRd;
  logic [31:0] LdData;
  logic        IssueLoad;
  logic [4:0]  IssueRd;
  logic [31:0] Pending;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic        RegWrite;

  int checks = 0;
  int errors = 0;
  wb_entry_t sb_q[$];

  writeback_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(3)) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .AluValid  (AluValid),
    .AluRd     (AluRd),
    .AluData   (AluData),
    .AluStall  (AluStall),
    .LdValid   (LdValid),
    .LdReady   (LdReady),
    .LdRd      (LdRd),
    .LdData    (LdData),
    .IssueLoad (IssueLoad),
    .IssueRd   (IssueRd),
    .Pending   (Pending),
    .A3        (A3),
    .WD3       (WD3),
    .RegWrite  (RegWrite)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic expect_wb(input logic [4:0] rd, input logic [31:0] data);
    sb_q.push_back('{rd: rd, data: data});
  endtask

  // Advance one clock, sample just after the edge and retire any write against the queue.
  task automatic step();
    wb_entry_t e;
    @(posedge CLK);
    #1;
    if (RegWrite === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_write", 32'(RegWrite), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("sb_a3", 32'(A3), 32'(e.rd));
        check("sb_wd3", WD3, e.data);
      end
    end
  endtask

  task automatic idle_inputs();
    AluValid  = 1'b0;
    AluRd     = '0;
    AluData   = '0;
    LdValid   = 1'b0;
    LdRd      = '0;
    LdData    = '0;
    IssueLoad = 1'b0;
    IssueRd   = '0;
  endtask

  initial begin
    RESET_N = 1'b0;
    idle_inputs();
    repeat (2) @(posedge CLK);
    #1;
    check("rst_regwrite", 32'(RegWrite), 32'd0);
    check("rst_a3", 32'(A3), 32'd0);
    check("rst_wd3", WD3, 32'd0);
    check("rst_alustall", 32'(AluStall), 32'd0);
    check("rst_pending", Pending, 32'd0);
    check("rst_ldready", 32'(LdReady), 32'd0);
    RESET_N = 1'b1;
    #1;
    check("rel_ldready", 32'(LdReady), 32'd1);

    // isolated load, ALU idle
    IssueLoad = 1'b1; IssueRd = 5'd5;
    step();
    IssueLoad = 1'b0;
    check("iso_pend_set", 32'(Pending[5]), 32'd1);
    LdValid = 1'b1; LdRd = 5'd5; LdData = 32'hDEAD_BEEF;
    #1;
    check("iso_ldready", 32'(LdReady), 32'd1);
    expect_wb(5'd5, 32'hDEAD_BEEF);
    step();
    LdValid = 1'b0;
    check("iso_lat1_regwrite", 32'(RegWrite), 32'd0);
    step();
    check("iso_lat2_regwrite", 32'(RegWrite), 32'd1);
    check("iso_pend_clr", 32'(Pending[5]), 32'd0);
    step();
    check("iso_one_cycle", 32'(RegWrite), 32'd0);
    check("iso_drained", 32'(sb_q.size()), 32'd0);

    // contention: one buffered load against continuous ALU traffic
    IssueLoad = 1'b1; IssueRd = 5'd9;
    LdValid = 1'b1; LdRd = 5'd9; LdData = 32'h1111_0009;
    step();
    IssueLoad = 1'b0; LdValid = 1'b0;
    check("con_pend9", 32'(Pending[9]), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      AluValid = 1'b1; AluRd = 5'(i); AluData = 32'hA000_0000 + 32'(i);
      expect_wb(5'(i), 32'hA000_0000 + 32'(i));
      step();
      check("con_alustall", 32'(AluStall), (i == 3) ? 32'd1 : 32'd0);
    end
    AluRd = 5'd4; AluData = 32'hA000_0004;
    expect_wb(5'd9, 32'h1111_0009);
    step();
    check("con_stall_drop", 32'(AluStall), 32'd0);
    check("con_starve_zero", 32'(dut.r_starve), 32'd0);
    check("con_pend9_clr", 32'(Pending[9]), 32'd0);
    expect_wb(5'd4, 32'hA000_0004);
    step();
    AluValid = 1'b0;
    step();
    check("con_drained", 32'(sb_q.size()), 32'd0);

    // full buffer: three back-to-back loads under ALU traffic
    AluValid = 1'b1; AluRd = 5'd13;
    AluData = 32'hB000_0000; LdValid = 1'b1; LdRd = 5'd10; LdData = 32'hC000_0010;
    check("full_rdy_d0", 32'(LdReady), 32'd1);
    expect_wb(5'd13, 32'hB000_0000);
    step();
    AluData = 32'hB000_0001; LdRd = 5'd11; LdData = 32'hC000_0011;
    check("full_rdy_d1", 32'(LdReady), 32'd1);
    expect_wb(5'd13, 32'hB000_0001);
    step();
    AluData = 32'hB000_0002; LdRd = 5'd12; LdData = 32'hC000_0012;
    check("full_rdy_d2", 32'(LdReady), 32'd0);
    expect_wb(5'd13, 32'hB000_0002);
    step();
    AluData = 32'hB000_0003;
    check("full_rdy_d3", 32'(LdReady), 32'd0);
    check("full_nostall_d3", 32'(AluStall), 32'd0);
    expect_wb(5'd13, 32'hB000_0003);
    step();
    AluData = 32'hB000_0004;
    check("full_stall_d4", 32'(AluStall), 32'd1);
    check("full_rdy_popcycle", 32'(LdReady), 32'd0);
    expect_wb(5'd10, 32'hC000_0010);
    step();
    check("full_rdy_after_pop", 32'(LdReady), 32'd1);
    expect_wb(5'd13, 32'hB000_0004);
    step();
    LdValid = 1'b0; AluValid = 1'b0;
    expect_wb(5'd11, 32'hC000_0011);
    step();
    expect_wb(5'd12, 32'hC000_0012);
    step();
    step();
    check("full_drained", 32'(sb_q.size()), 32'd0);

    // x0 load: popped but never written; x0 issue never sets Pending
    IssueLoad = 1'b1; IssueRd = 5'd20;
    step();
    IssueRd = 5'd0;
    step();
    IssueLoad = 1'b0;
    check("x0_issue_pend", Pending, 32'h0010_0000);
    LdValid = 1'b1; LdRd = 5'd0; LdData = 32'h1234_5678;
    step();
    LdValid = 1'b0;
    step();
    check("x0_regwrite", 32'(RegWrite), 32'd0);
    check("x0_pend_same", Pending, 32'h0010_0000);
    check("x0_fifo_empty", 32'(dut.w_fifo_empty), 32'd1);

    // re-issue to x7 in the cycle its pending load is selected for writeback
    IssueLoad = 1'b1; IssueRd = 5'd7;
    step();
    IssueLoad = 1'b0;
    LdValid = 1'b1; LdRd = 5'd7; LdData = 32'h0000_0077;
    step();
    LdValid = 1'b0;
    IssueLoad = 1'b1; IssueRd = 5'd7;
    expect_wb(5'd7, 32'h0000_0077);
    step();
    IssueLoad = 1'b0;
    check("col_regwrite", 32'(RegWrite), 32'd1);
    check("col_pend7", 32'(Pending[7]), 32'd1);
    check("col_pend_all", Pending, 32'h0010_0080);
    step();
    check("col_drained", 32'(sb_q.size()), 32'd0);

    // reset with two loads buffered
    AluValid = 1'b1; AluRd = 5'd3; AluData = 32'hD000_0000;
    LdValid = 1'b1; LdRd = 5'd21; LdData = 32'hE000_0021;
    expect_wb(5'd3, 32'hD000_0000);
    step();
    AluData = 32'hD000_0001; LdRd = 5'd22; LdData = 32'hE000_0022;
    expect_wb(5'd3, 32'hD000_0001);
    step();
    check("rmf_full", 32'(LdReady), 32'd0);
    idle_inputs();
    RESET_N = 1'b0;
    #1;
    check("rmf_rst_regwrite", 32'(RegWrite), 32'd0);
    check("rmf_rst_pending", Pending, 32'd0);
    check("rmf_rst_ldready", 32'(LdReady), 32'd0);
    step();
    step();
    RESET_N = 1'b1;
    #1;
    check("rmf_rel_ldready", 32'(LdReady), 32'd1);
    repeat (4) step();
    check("rmf_pending", Pending, 32'd0);
    check("rmf_regwrite", 32'(RegWrite), 32'd0);
    check("rmf_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 2, giving the number of load-result buffer entries (power of two, at least 2).
REQ-002 The block SHALL have parameter STARVE_LIMIT, default 3, giving the number of consecutive blocked cycles before the ALU path is stalled.
REQ-003 Port CLK  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port RESET_N  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 Port AluValid  input  1  means the ALU result is valid this cycle.
REQ-006 Port AluRd  input  5  is the ALU destination register.
REQ-007 Port AluData  input  32  is the ALU result.
REQ-008 Port AluStall  output  1  means upstream SHALL hold its ALU result and AluValid this cycle.
REQ-009 Port LdValid  input  1  means the load unit is offering a result.
REQ-010 Port LdReady  output  1  means the block accepts a load result this cycle.
REQ-011 Port LdRd  input  5  is the load destination register.
REQ-012 Port LdData  input  32  is the load data.
REQ-013 Port IssueLoad  input  1  means a load is issued this cycle, marking IssueRd as pending.
REQ-014 Port IssueRd  input  5  is the destination register of the issued load.
REQ-015 Port Pending  output  32  is the per-register scoreboard; bit i set means a load to xi is outstanding.
REQ-016 Port A3  output  5  is the register-file write address.
REQ-017 Port WD3  output  32  is the register-file write data.
REQ-018 Port RegWrite  output  1  is the register-file write enable.

Function
REQ-019 A3, WD3 and RegWrite SHALL be registered: a write selected in cycle N SHALL appear in cycle N+1 for exactly one cycle.
REQ-020 A load transfer SHALL occur when LdValid and LdReady are both high; each transferred result SHALL be pushed into the FIFO.
REQ-021 LdReady SHALL equal (FIFO count < FIFO_DEPTH), decoded from registered count only, with no same-cycle pop pass-through.
REQ-022 Write selection each cycle: if AluValid and not AluStall, the ALU result SHALL be selected; otherwise, if the FIFO is non-empty, the FIFO head SHALL be selected and popped; otherwise nothing SHALL be selected.
REQ-023 Loads SHALL retire in acceptance order; the minimum latency from load accept to RegWrite SHALL be 2 cycles.
REQ-024 Starvation counter: it SHALL increment when the FIFO is non-empty and the ALU wins, SHALL reset to 0 when the head pops or the FIFO is empty, and SHALL saturate at STARVE_LIMIT.
REQ-025 AluStall SHALL be high (registered) in the cycle after the counter reaches STARVE_LIMIT; in that cycle the FIFO head SHALL be written and AluValid ignored.
REQ-026 Writes to rd=0 SHALL be selected and popped normally but SHALL produce RegWrite=0.
REQ-027 Pending[IssueRd] SHALL set on IssueLoad when IssueRd!=0; Pending[0] SHALL always be 0.
REQ-028 Pending[rd] SHALL clear in the cycle that load's RegWrite is asserted.
REQ-029 If a set and a clear hit the same rd in the same cycle, the bit SHALL remain set.
REQ-030 When the FIFO is full and the head pops, LdReady SHALL become 1 in the next cycle, not the same cycle.
REQ-031 Read-after-write and write-after-write ordering between the ALU and load paths is the issue logic's responsibility, using Pending; this block SHALL NOT reorder or merge writes.

Reset
REQ-032 While RESET_N is low: RegWrite, A3, WD3, AluStall and Pending SHALL be 0, FIFO count SHALL be 0, the starvation counter SHALL be 0, and LdReady SHALL be forced to 0.
REQ-033 In the first cycle after RESET_N deasserts, LdReady SHALL be 1.
REQ-034 Reset asserted mid-operation SHALL discard all buffered loads with no further RegWrite.

Structure
REQ-035 XLEN=32, REG_ADDR_W=5 and a wb_entry_t struct {rd, data} SHALL live in the shared package riscv_pkg.
REQ-036 The FIFO SHALL be a sub-module wb_fifo with push/pop/full/empty/count ports.

Verification
REQ-037 Isolated load: LdValid with LdRd=5, LdData=0xDEADBEEF, ALU idle -> RegWrite=1, A3=5, WD3=0xDEADBEEF exactly 2 cycles after accept; Pending[5] clears that cycle.
REQ-038 Contention: AluValid continuous while one load is buffered -> ALU writes for 3 cycles, then AluStall=1, then the load writes; the counter returns to 0.
REQ-039 Full buffer: 3 back-to-back loads under continuous ALU traffic -> LdReady=0 after 2 accepts, and returns to 1 the cycle after the first pop.
REQ-040 x0: load with LdRd=0 -> FIFO pops, RegWrite stays 0, and Pending is unchanged.
REQ-041 Scoreboard collision: IssueLoad with IssueRd=7 in the same cycle a pending x7 load retires -> Pending[7] remains 1.
REQ-042 Reset mid-flight: 2 loads buffered, RESET_N pulsed low -> no RegWrite, Pending=0, and LdReady=1 one cycle after release.
